router_fifo: RTL
================

# router_fifo

Per-port output FIFO of the 1x3 packet router, sitting directly downstream of `synchronizer`. One instance exists per destination port. Each instance accepts bytes when `synchronizer` asserts its `wr_en` bit and hands bytes to the port reader. It reports `full` and `empty` back to `synchronizer`, and is flushed when the matching `soft_reset_N` fires. Every entry carries a header flag so the block can track packet boundaries on the read side.

## Interface
Parameters:
- `DATA_W`, 8, byte width.
- `DEPTH`, 16, number of entries; must be a power of two.
- `ADDR_W`, 4, log2(`DEPTH`).

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `soft_reset`  in  1  synchronous flush, from `synchronizer` `soft_reset_N`.
- `wr_en`  in  1  write strobe, from `synchronizer` `wr_en[N]`.
- `rd_en`  in  1  read strobe, from the port reader.
- `lfd_state`  in  1  marks the byte being written as a packet header.
- `data_in`  in  `DATA_W`  write data.
- `data_out`  out  `DATA_W`  registered read data.
- `full`  out  1  FIFO holds `DEPTH` entries.
- `empty`  out  1  FIFO holds 0 entries.
- `ovf`  out  1  sticky overflow flag; present only with `FIFO_OVF_FLAG_EN`.

## Operation
- **Storage:** `DEPTH` x (`DATA_W`+1) bits. The MSB of each entry stores `lfd_state` as sampled at write.
- **Pointers:** `wr_ptr` and `rd_ptr` are `ADDR_W`+1 bits, with natural wrap-around.
  - `empty` = pointers equal.
  - `full` = MSBs differ and the low `ADDR_W` bits are equal.
- **Write:** accepted when `wr_en` && !`full`. The entry is stored and `wr_ptr` increments. A write while `full` is dropped and no state changes.
- **Read:** accepted when `rd_en` && !`empty`. `data_out` is loaded with the entry's low `DATA_W` bits and `rd_ptr` increments. A read while `empty` is ignored.
- **Simultaneous read and write:** both are performed independently, each gated by the registered `full`/`empty`.
  - When `full`, the write is still blocked even if a read occurs in the same cycle.
  - When `empty`, the read is still blocked even if a write occurs in the same cycle.
- **Packet counter `pkt_cnt` (6 bits):**
  - Reading a header-flagged entry loads `pkt_cnt` with `data[7:2]` + 1 (payload length plus parity byte).
  - Reading a non-header entry with `pkt_cnt` != 0 decrements `pkt_cnt`.
  - When `pkt_cnt` == 0 and no read occurs in a cycle, `data_out` is cleared to 0. Otherwise `data_out` holds its value.
- **`soft_reset`:** clears both pointers, `pkt_cnt`, `data_out`, all storage entries and `ovf`. It has priority over a same-cycle write or read.
- **`rst` low:** clears the same state immediately, independent of `clk`. This applies mid-packet as well; partial packets are discarded.

## Timing
- Reset values: `data_out`=0, `full`=0, `empty`=1, `ovf`=0.
- Read latency is 1 cycle: a `rd_en` sampled at edge k produces `data_out` valid after edge k.
- `full`/`empty` are combinational from the registered pointers, so they change in the cycle after the edge that moved a pointer.
- After a write into an empty FIFO, `empty` deasserts 1 cycle later, and a read is possible from the next edge.
- The 16th write raises `full` in the following cycle. One read then clears `full` in the following cycle.
- On a pointer wrap from 15 to 0, the MSB toggles and no entry is lost.
- When `soft_reset` and `wr_en` are both high, nothing is stored and `empty`=1 in the next cycle.

## Configuration
- Macro: `FIFO_OVF_FLAG_EN`.
- Defined: port `ovf` exists. `ovf` sets on any cycle with `wr_en` && `full` and stays set until `rst` or `soft_reset`.
- Undefined: the `ovf` port and its register are absent, and dropped writes are silent.
- All other behaviour is identical in both builds.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles, then release. Expect `empty`=1, `full`=0, `data_out`=0x00, `ovf`=0.
- **Short packet:** write header 0x0D (length 3, `lfd_state`=1), then 0x11, 0x22, 0x33 and parity 0x5A; then assert `rd_en` for 5 cycles.
  - Expect `data_out` to read 0x0D, 0x11, 0x22, 0x33, 0x5A on consecutive cycles.
  - Expect `data_out`=0x00 on the first idle cycle after that.
- **Fill and overflow:** write 16 bytes; expect `full`=1. Write 0xFF once more.
  - Expect the byte to be dropped and `ovf`=1 (macro defined).
  - Read 16 bytes; expect the original order and `empty`=1 afterwards.
- **Wrap-around:** repeat 10 writes followed by 10 reads, 4 times. Expect data to match every time, and `full` never asserted.
- **Flush mid-packet:** write 5 bytes, then pulse `soft_reset` together with a write of 0x77.
  - Expect `empty`=1 the next cycle and `data_out`=0.
  - Expect a subsequent single write/read to return the new byte.
- **Simultaneous access at `full`:** assert `rd_en` and `wr_en` together while `full`. Expect one byte read, the write dropped, and `full`=0 the next cycle.

Source files
------------

// File: rtl/router_fifo.sv
// router_fifo: per-port output FIFO of the 1x3 packet router.
// Accepts bytes from the synchronizer on wr_en and hands them to the port
// reader on rd_en. Each entry keeps a header flag (lfd_state at write time).
// The read side uses this flag to track packet boundaries with pkt_cnt.
// Optional feature macro: FIFO_OVF_FLAG_EN adds the sticky ovf output.
//
// Ports:
//   clk         single clock, rising edge
//   rst         asynchronous active-low reset
//   soft_reset  synchronous flush (from synchronizer soft_reset_N)
//   wr_en       write strobe
//   rd_en       read strobe
//   lfd_state   marks the byte being written as a packet header
//   data_in     write data
//   data_out    registered read data
//   full        FIFO holds DEPTH entries
//   empty       FIFO holds no entries
//   ovf         sticky overflow flag (FIFO_OVF_FLAG_EN builds only)
module router_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              soft_reset,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic              lfd_state,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              full,
   output logic              empty
`ifdef FIFO_OVF_FLAG_EN
   ,
   output logic              ovf
`endif
);

   localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

   logic [DATA_W:0] mem [DEPTH];
   logic [ADDR_W:0] wr_ptr;
   logic [ADDR_W:0] rd_ptr;
   logic [5:0]      pkt_cnt;
   logic [DATA_W:0] rd_entry;
   logic            do_wr;
   logic            do_rd;

   // Extra pointer MSB distinguishes full from empty when the low bits match.
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

   // Both strobes are gated by the registered flags. A read therefore
   // cannot make room for a same-cycle write, and a write cannot feed a
   // same-cycle read.
   assign do_wr    = wr_en && !full;
   assign do_rd    = rd_en && !empty;
   assign rd_entry = mem[rd_ptr[ADDR_W-1:0]];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         pkt_cnt  <= '0;
         data_out <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (soft_reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         pkt_cnt  <= '0;
         data_out <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_wr) begin
            mem[wr_ptr[ADDR_W-1:0]] <= {lfd_state, data_in};
            wr_ptr                  <= wr_ptr + PTR_ONE;
         end
         if (do_rd) begin
            data_out <= rd_entry[DATA_W-1:0];
            rd_ptr   <= rd_ptr + PTR_ONE;
            // A header carries the payload length in bits [7:2]. The extra
            // count covers the trailing parity byte.
            if (rd_entry[DATA_W])
               pkt_cnt <= 6'(rd_entry[DATA_W-1:2]) + 6'd1;
            else if (pkt_cnt != 6'd0)
               pkt_cnt <= pkt_cnt - 6'd1;
         end else if (pkt_cnt == 6'd0) begin
            // Between packets the output bus idles at zero.
            data_out <= '0;
         end
      end
   end

`ifdef FIFO_OVF_FLAG_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         ovf <= 1'b0;
      else if (soft_reset)
         ovf <= 1'b0;
      else if (wr_en && full)
         ovf <= 1'b1;
   end
`endif

endmodule
